regfile_loader: RTL

REGFILE_LOADER -- requirements
Module: regfile_loader

---
 rtl/regfile_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_loader.sv
// Serial frame loader: shifts {WA2,WA1,WA0,LD_DATA} in MSB first and issues one register-file write.
// Optional build macro REGFILE_LOADER_PARITY_EN appends a trailing even-parity bit to each frame.
module regfile_loader #(
    parameter int TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       CLRN,
    input  logic       START,
    input  logic       SIN,
    input  logic       SVALID,
    output logic       RDY,
    output logic       WA2,
    output logic       WA1,
    output logic       WA0,
    output logic [3:0] LD_DATA,
    output logic       WR,
    output logic       ERR,
    output logic [7:0] WCNT
);

`ifdef REGFILE_LOADER_PARITY_EN
    localparam int FRAME_W = 8;
`else
    localparam int FRAME_W = 7;
`endif

    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);
    localparam logic [7:0] TMO_LIM  = 8'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         tmo_cnt_q, tmo_cnt_d;
    logic [FRAME_W-1:0] frame_q,   frame_d;
    logic [6:0]         wdata_q,   wdata_d;
    logic               err_q,     err_d;
    logic [7:0]         wcnt_q,    wcnt_d;
    logic [FRAME_W-1:0] frame_next;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        frame_d    = frame_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        wcnt_d     = wcnt_q;
        frame_next = {frame_q[FRAME_W-2:0], SIN};

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                    frame_d   = '0;
                    err_d     = 1'b0;
                end
            end
            S_SHIFT: begin
                // START has priority: the frame restarts and SIN this cycle is dropped
                if (START) begin
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                    frame_d   = '0;
                end else if (SVALID) begin
                    frame_d   = frame_next;
                    tmo_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef REGFILE_LOADER_PARITY_EN
                        if (^frame_next) begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_WRITE;
                            wdata_d = frame_next[7:1];
                        end
`else
                        state_d = S_WRITE;
                        wdata_d = frame_next;
`endif
                    end
                end else if (tmo_cnt_q + 8'd1 == TMO_LIM) begin
                    state_d   = S_IDLE;
                    err_d     = 1'b1;
                    tmo_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                wcnt_d  = wcnt_q + 8'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            frame_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            frame_q   <= frame_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign RDY           = (state_q == S_SHIFT);
    assign WR            = (state_q == S_WRITE);
    assign {WA2,WA1,WA0} = wdata_q[6:4];
    assign LD_DATA       = wdata_q[3:0];
    assign ERR           = err_q;
    assign WCNT          = wcnt_q;

endmodule
